pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Sequential instruction fetch front end: owns the architectural PC register, steps it by PC_STEP
//   through the 32-bit PC adder/mux datapath, and issues addresses to instruction memory
//   (req/ack, variable latency). Returned words are buffered in a DEPTH-entry FIFO and presented
//   to decode via valid/ready. Sits between the imem port and the IF/ID stage. Execute redirects
//   (branch/jump) flush it.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset; first fetch address
//   PC_STEP    32'd4          PC increment per sequential fetch
//   DEPTH      2              instruction FIFO entries (power of two, >=2)
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous active-low reset
//   redirect_i     in   1   flush and restart fetch at redirect_pc_i
//   redirect_pc_i  in   32  new fetch PC
//   imem_req_o     out  1   fetch request; held until imem_ack_i
//   imem_addr_o    out  32  fetch address; stable while imem_req_o=1
//   imem_ack_i     in   1   imem data valid this cycle (1-cycle pulse)
//   imem_rdata_i   in   32  instruction word, valid with imem_ack_i
//   if_valid_o     out  1   FIFO head valid
//   if_ready_i     in   1   decode accepts head
//   if_instr_o     out  32  head instruction
//   if_pc_o        out  32  head PC
//   if_pcplus_o    out  32  head PC + PC_STEP
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_PC, FIFO empty, state=IDLE; imem_req_o=0, if_valid_o=0,
//     imem_addr_o=RESET_PC, if_instr_o/if_pc_o/if_pcplus_o=0.
//   FSM: IDLE -> REQ when FIFO has a free slot not reserved by an outstanding fetch.
//     REQ: imem_req_o=1, imem_addr_o=pc. On ack: push {pc, rdata}, pc<=pc+PC_STEP (32-bit wrap,
//       0xFFFF_FFFC+4=0), stay REQ if a slot remains, else IDLE.
//     DROP: entered on redirect while a request is outstanding; imem_req_o stays 1 on the
//       old address until ack; acked word discarded; then REQ at the redirected pc.
//   Max one outstanding request. Ack with FIFO full cannot occur (slot reserved at issue).
//   Redirect (highest priority): FIFO flushed same edge; pc<=redirect_pc_i; if_valid_o=0 next
//     cycle; redirect with same-cycle ack -> ack word dropped, no DROP state needed;
//     redirect in DROP updates the target only.
//   Latency: ack in cycle N -> if_valid_o=1 in N+1. Zero-wait imem sustains 1 instr/cycle.
//   Handshake: pop on if_valid_o & if_ready_i; push and pop same cycle allowed when full
//     (count unchanged). Head outputs stable while if_valid_o=1 & if_ready_i=0.
//   FIFO pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
// CONFIGURATION
//   FETCH_MISALIGN_CHK_EN defined: adds output fetch_misalign_o (1 bit, reset 0). pc[1:0]!=0 at
//     issue time -> no request, fetch_misalign_o=1 held, FSM parks in IDLE until next
//     redirect_i (clears flag). Undefined: no port, pc[1:0] ignored, misaligned addresses issued.
// TESTING
//   Reset release, ack next cycle every request -> addrs 0x0,0x4,0x8..., one instr/cycle.
//   if_ready_i=0 for 5 cycles -> 2 entries held, imem_req_o=0, head PC 0x0 stable.
//   Redirect to 0x100 with request pending at 0x8 -> ack for 0x8 dropped; next head PC 0x100.
//   Redirect same cycle as ack -> word dropped, next imem_addr_o=redirect_pc_i, no DROP state.
//   Redirect to 0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; if_pcplus_o wraps to 0x0.
//   With FETCH_MISALIGN_CHK_EN: redirect to 0x102 -> fetch_misalign_o=1, no req; redirect 0x200 clears.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Sequential instruction fetch front end. Holds the PC, issues
//               req/ack fetches to instruction memory (one outstanding at a
//               time), buffers returned words in a DEPTH-entry FIFO and hands
//               them to decode over valid/ready. Redirects flush the FIFO.
// Options     : FETCH_MISALIGN_CHK_EN - adds fetch_misalign_o; a misaligned
//               PC parks the fetcher until the next redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pcplus_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_pc;
  logic [31:0]          r_drop_addr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_count_after;
  logic [31:0]          r_mem_pc    [DEPTH];
  logic [31:0]          r_mem_instr [DEPTH];
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_misalign;
  logic                 w_park;
  logic                 w_set_misalign;

  assign w_full = (r_count == c_CNT_W'(DEPTH));
  assign w_pop  = (r_count != '0) && if_ready_i;
  // Occupancy after a push this cycle, used to decide whether to keep fetching.
  assign w_count_after = r_count + c_CNT_W'(1) - c_CNT_W'(w_pop);

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  assign w_misalign       = (r_pc[1:0] != 2'b00);
  assign w_park           = r_misalign;
  assign fetch_misalign_o = r_misalign;

  // Sticky misalignment flag, cleared only by a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_misalign <= 1'b0;
    else if (redirect_i)     r_misalign <= 1'b0;
    else if (w_set_misalign) r_misalign <= 1'b1;
  end
`else
  assign w_misalign = 1'b0;
  assign w_park     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic, request strobe and push decision.
  always_comb begin
    w_state_nxt    = r_state;
    imem_req_o     = 1'b0;
    w_push         = 1'b0;
    w_set_misalign = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A redirect flushes the FIFO, so a slot is always free afterwards.
        if (redirect_i)               w_state_nxt = S_REQ;
        else if (!w_full && !w_park)  w_state_nxt = S_REQ;
      end
      S_REQ: begin
        imem_req_o = !w_misalign;
        if (redirect_i) begin
          // Only a request still in flight needs its returning word discarded.
          w_state_nxt = (imem_ack_i || w_misalign) ? S_REQ : S_DROP;
        end else if (w_misalign) begin
          w_set_misalign = 1'b1;
          w_state_nxt    = S_IDLE;
        end else if (imem_ack_i) begin
          w_push      = 1'b1;
          w_state_nxt = (w_count_after < c_CNT_W'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // During DROP the old address must stay on the bus while r_pc holds the target.
  assign imem_addr_o = (r_state == S_DROP) ? r_drop_addr : r_pc;

  // PC and the address of a request being abandoned by a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      if (redirect_i && (r_state == S_REQ) && !imem_ack_i)
        r_drop_addr <= r_pc;
      if (redirect_i)  r_pc <= redirect_pc_i;
      else if (w_push) r_pc <= r_pc + PC_STEP;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_pc;
      r_mem_instr[r_wr_ptr] <= imem_rdata_i;
    end
  end

  assign if_valid_o  = (r_count != '0);
  assign if_instr_o  = if_valid_o ? r_mem_instr[r_rd_ptr] : 32'd0;
  assign if_pc_o     = if_valid_o ? r_mem_pc[r_rd_ptr] : 32'd0;
  assign if_pcplus_o = if_valid_o ? (r_mem_pc[r_rd_ptr] + PC_STEP) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit. Instruction
//               memory returns addr + 0x1000_0000 as the instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pcplus_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misalign_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pcplus_o   (if_pcplus_o)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then settle 1 time unit past the edge.
  task automatic drive(input logic ack, input logic rdy);
    imem_ack_i   = ack;
    imem_rdata_i = imem_addr_o + 32'h1000_0000;
    if_ready_i   = rdy;
    @(posedge clk);
    #1;
    imem_ack_i    = 1'b0;
    redirect_i    = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held
    #12;
    check("rst_req",    {31'd0, imem_req_o}, 32'd0);
    check("rst_addr",   imem_addr_o, 32'h0);
    check("rst_valid",  {31'd0, if_valid_o}, 32'd0);
    check("rst_instr",  if_instr_o, 32'd0);
    check("rst_pc",     if_pc_o, 32'd0);
    check("rst_pcplus", if_pcplus_o, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("rst_misalign", {31'd0, fetch_misalign_o}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;

    // Sequential fetch with zero-wait memory
    drive(1'b0, 1'b1);
    check("seq_req0",  {31'd0, imem_req_o}, 32'd1);
    check("seq_addr0", imem_addr_o, 32'h0);
    drive(1'b1, 1'b1);
    check("seq_addr4",   imem_addr_o, 32'h4);
    check("seq_valid0",  {31'd0, if_valid_o}, 32'd1);
    check("seq_hpc0",    if_pc_o, 32'h0);
    check("seq_instr0",  if_instr_o, 32'h1000_0000);
    check("seq_pcplus0", if_pcplus_o, 32'h4);
    drive(1'b1, 1'b1);
    check("seq_addr8",  imem_addr_o, 32'h8);
    check("seq_hpc4",   if_pc_o, 32'h4);
    check("seq_instr4", if_instr_o, 32'h1000_0004);

    // Decode stalls: FIFO fills, requests stop, head held
    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_req",   {31'd0, imem_req_o}, 32'd0);
      check("stall_valid", {31'd0, if_valid_o}, 32'd1);
      check("stall_hpc",   if_pc_o, 32'h4);
      check("stall_instr", if_instr_o, 32'h1000_0004);
      drive(1'b0, 1'b0);
    end
    check("stall_pc_next", imem_addr_o, 32'hC);
    drive(1'b0, 1'b1);
    check("drain_hpc8", if_pc_o, 32'h8);
    check("drain_req",  {31'd0, imem_req_o}, 32'd0);
    drive(1'b0, 1'b1);
    check("resume_req",   {31'd0, imem_req_o}, 32'd1);
    check("resume_addr",  imem_addr_o, 32'hC);
    check("resume_valid", {31'd0, if_valid_o}, 32'd0);

    // Redirect while request at 0xC is outstanding
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    drive(1'b0, 1'b1);
    check("drop_req",   {31'd0, imem_req_o}, 32'd1);
    check("drop_addr",  imem_addr_o, 32'hC);
    check("drop_valid", {31'd0, if_valid_o}, 32'd0);
    drive(1'b1, 1'b1);
    check("drop_discard", {31'd0, if_valid_o}, 32'd0);
    check("redir_addr",   imem_addr_o, 32'h100);
    check("redir_req",    {31'd0, imem_req_o}, 32'd1);
    drive(1'b1, 1'b1);
    check("redir_hpc",   if_pc_o, 32'h100);
    check("redir_instr", if_instr_o, 32'h1000_0100);
    check("redir_next",  imem_addr_o, 32'h104);

    // Redirect coinciding with an ack: word dropped, no DROP phase
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    drive(1'b1, 1'b0);
    check("sameack_valid", {31'd0, if_valid_o}, 32'd0);
    check("sameack_req",   {31'd0, imem_req_o}, 32'd1);
    check("sameack_addr",  imem_addr_o, 32'hFFFF_FFF8);

    // Wrap-around of the PC
    drive(1'b1, 1'b1);
    check("wrap_hpc0",    if_pc_o, 32'hFFFF_FFF8);
    check("wrap_pcplus0", if_pcplus_o, 32'hFFFF_FFFC);
    check("wrap_addr1",   imem_addr_o, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1);
    check("wrap_hpc1",    if_pc_o, 32'hFFFF_FFFC);
    check("wrap_pcplus1", if_pcplus_o, 32'h0);
    check("wrap_instr1",  if_instr_o, 32'h0FFF_FFFC);
    check("wrap_addr2",   imem_addr_o, 32'h0);
    drive(1'b1, 1'b1);
    check("wrap_hpc2",  if_pc_o, 32'h0);
    check("wrap_addr3", imem_addr_o, 32'h4);

    // Misaligned redirect target
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    drive(1'b1, 1'b1);
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_noreq0", {31'd0, imem_req_o}, 32'd0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    check("mis_flag",   {31'd0, fetch_misalign_o}, 32'd1);
    check("mis_noreq1", {31'd0, imem_req_o}, 32'd0);
    check("mis_valid",  {31'd0, if_valid_o}, 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    drive(1'b0, 1'b1);
    check("mis_clear", {31'd0, fetch_misalign_o}, 32'd0);
    check("mis_req",   {31'd0, imem_req_o}, 32'd1);
    check("mis_addr",  imem_addr_o, 32'h200);
`else
    check("mis_req",  {31'd0, imem_req_o}, 32'd1);
    check("mis_addr", imem_addr_o, 32'h102);
    drive(1'b1, 1'b1);
    check("mis_hpc",  if_pc_o, 32'h102);
    check("mis_next", imem_addr_o, 32'h106);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
